// File: rtl/serial_word_comparator.sv
// Bit-serial, MSB-first comparator for two WIDTH-bit words.
// Reports EQ/GT/LT and Hamming distance with a START/BUSY/DONE handshake.

module bit_comparison (
    input  logic A,
    input  logic B,
    output logic Y
);
    assign Y = ~(A ^ B);
endmodule

module serial_word_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             BIT_VALID,
    input  logic             A,
    input  logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             EQ,
    output logic             GT,
    output logic             LT,
    output logic [CNT_W-1:0] MISMATCH_CNT,
    output logic [1:0]       STATE_DBG
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic             decided_q, decided_d;
    logic             gt_acc_q, gt_acc_d;
    logic             lt_acc_q, lt_acc_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             done_q, done_d;

    logic             bit_eq;
    logic             accept;
    logic             sample;

    bit_comparison u_bit_comparison (
        .A (A),
        .B (B),
        .Y (bit_eq)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        mis_d     = mis_q;
        decided_d = decided_q;
        gt_acc_d  = gt_acc_q;
        lt_acc_d  = lt_acc_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        cnt_out_d = cnt_out_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SHIFT;
                    accept  = 1'b1;
                end
            end
            S_SHIFT: begin
                // START is deliberately not looked at here: a word in flight cannot be restarted.
                if (BIT_VALID) begin
                    sample = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (START) begin
                    state_d = S_SHIFT;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            bit_cnt_d = '0;
            mis_d     = '0;
            decided_d = 1'b0;
            gt_acc_d  = 1'b0;
            lt_acc_d  = 1'b0;
        end

        if (sample) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (!bit_eq) begin
                mis_d = mis_q + 1'b1;
                // Only the first (most significant) difference sets the ordering.
                if (!decided_q) begin
                    decided_d = 1'b1;
                    gt_acc_d  = A & ~B;
                    lt_acc_d  = ~A & B;
                end
            end
            if (bit_cnt_q == LAST_BIT) begin
                eq_d      = ~decided_d;
                gt_d      = gt_acc_d;
                lt_d      = lt_acc_d;
                cnt_out_d = mis_d;
                done_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            mis_q     <= '0;
            decided_q <= 1'b0;
            gt_acc_q  <= 1'b0;
            lt_acc_q  <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            cnt_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            mis_q     <= mis_d;
            decided_q <= decided_d;
            gt_acc_q  <= gt_acc_d;
            lt_acc_q  <= lt_acc_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            cnt_out_q <= cnt_out_d;
            done_q    <= done_d;
        end
    end

    assign BUSY         = (state_q == S_SHIFT);
    assign DONE         = done_q;
    assign EQ           = eq_q;
    assign GT           = gt_q;
    assign LT           = lt_q;
    assign MISMATCH_CNT = cnt_out_q;
    assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator: a driver issues words and pushes
// hand-computed results; a monitor pops and compares on every DONE.

module tb_serial_word_comparator;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int EW    = 32 + 3 + CNT_W;

    logic             clk;
    logic             rst;
    logic             start;
    logic             bit_valid;
    logic             a_in;
    logic             b_in;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [CNT_W-1:0] mis_cnt;
    logic [1:0]       state_dbg;

    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;

    // Entry: {expected DONE cycle, eq, gt, lt, mismatch count}
    logic [EW-1:0]    exp_q[$];

    serial_word_comparator #(.WIDTH(WIDTH)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .START        (start),
        .BIT_VALID    (bit_valid),
        .A            (a_in),
        .B            (b_in),
        .BUSY         (busy),
        .DONE         (done),
        .EQ           (eq),
        .GT           (gt),
        .LT           (lt),
        .MISMATCH_CNT (mis_cnt),
        .STATE_DBG    (state_dbg)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d entries still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic apply_reset();
        #2;
        rst       = 1'b1;
        start     = 1'($urandom_range(0, 1));
        bit_valid = 1'($urandom_range(0, 1));
        a_in      = 1'($urandom_range(0, 1));
        b_in      = 1'($urandom_range(0, 1));
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_flags", {29'd0, eq, gt, lt}, 32'd0);
        check("rst_cnt", {28'd0, mis_cnt}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic run_word(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] stall_mask, input bit mid_start,
                            input bit b2b, input int abort_after,
                            input logic exp_eq, input logic exp_gt, input logic exp_lt,
                            input logic [CNT_W-1:0] exp_cnt);
        int nstall;
        nstall = $countones(stall_mask);
        if (!b2b) @(negedge clk);
        start     = 1'b1;
        bit_valid = 1'($urandom_range(0, 1));
        a_in      = 1'($urandom_range(0, 1));
        b_in      = 1'($urandom_range(0, 1));
        if (abort_after >= WIDTH)
            exp_q.push_back({cyc + 1 + WIDTH + nstall, exp_eq, exp_gt, exp_lt, exp_cnt});
        @(negedge clk);
        start = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (abort_after == WIDTH - 1 - i) begin
                apply_reset();
                return;
            end
            check("busy_shift", {31'd0, busy}, 32'd1);
            if (stall_mask[i]) begin
                bit_valid = 1'b0;
                a_in      = 1'($urandom_range(0, 1));
                b_in      = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("busy_stall", {31'd0, busy}, 32'd1);
            end
            bit_valid = 1'b1;
            a_in      = a[i];
            b_in      = b[i];
            start     = mid_start && (i == WIDTH - 4);
            @(negedge clk);
            start = 1'b0;
        end
        bit_valid = 1'b0;
        a_in      = 1'($urandom_range(0, 1));
        b_in      = 1'($urandom_range(0, 1));
        check("busy_fin", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard monitor
    initial begin
        logic [EW-1:0]      e;
        logic [3+CNT_W-1:0] held;
        logic               prev_done;
        held      = '0;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                held      = '0;
                prev_done = 1'b0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {25'd0, eq, gt, lt, mis_cnt}, {25'd0, e[3+CNT_W-1:0]});
                    check("done_cycle", cyc, e[EW-1:3+CNT_W]);
                    check("onehot", {31'd0, 1'($countones({eq, gt, lt}) == 1)}, 32'd1);
                    held = e[3+CNT_W-1:0];
                end
                check("done_pulse", {31'd0, prev_done}, 32'd0);
                prev_done = 1'b1;
            end else begin
                check("held", {25'd0, eq, gt, lt, mis_cnt}, {25'd0, held});
                prev_done = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        a_in      = 1'b0;
        b_in      = 1'b0;
        repeat (2) @(negedge clk);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_out", {24'd0, done, eq, gt, lt, mis_cnt}, 32'd0);
        rst = 1'b0;

        //        a      b      stalls        mid b2b abort eq    gt    lt    cnt
        run_word(8'hA5, 8'hA5, 8'b0000_0000, 0, 0, 8, 1'b1, 1'b0, 1'b0, 4'd0);
        run_word(8'h80, 8'h7F, 8'b0000_0000, 0, 0, 8, 1'b0, 1'b1, 1'b0, 4'd8);
        run_word(8'h7F, 8'h80, 8'b0000_0000, 0, 0, 8, 1'b0, 1'b0, 1'b1, 4'd8);
        run_word(8'h12, 8'h13, 8'b0100_1010, 0, 0, 8, 1'b0, 1'b0, 1'b1, 4'd1);
        run_word(8'h5A, 8'h4B, 8'b0000_0000, 1, 0, 8, 1'b0, 1'b1, 1'b0, 4'd2);
        run_word(8'h0F, 8'hF0, 8'b0000_0000, 0, 1, 8, 1'b0, 1'b0, 1'b1, 4'd8);
        run_word(8'hC3, 8'hC3, 8'b0000_0000, 0, 1, 8, 1'b1, 1'b0, 1'b0, 4'd0);
        run_word(8'h01, 8'h00, 8'b0000_0000, 0, 0, 8, 1'b0, 1'b1, 1'b0, 4'd1);

        repeat (2) @(negedge clk);
        apply_reset();

        run_word(8'hFF, 8'h00, 8'b0000_0000, 0, 0, 4, 1'b0, 1'b1, 1'b0, 4'd8);
        run_word(8'h3C, 8'h3C, 8'b0000_0000, 0, 0, 8, 1'b1, 1'b0, 1'b0, 4'd0);
        run_word(8'hFF, 8'h00, 8'b0010_0000, 0, 0, 8, 1'b0, 1'b1, 1'b0, 4'd8);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) check("pending_results", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
